multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised multi-cycle control unit for the RV32I datapath, replacing single-cycle main decoding with a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several cycles sharing one ALU and one memory port. It sits between the instruction register (opcode in) and the shared datapath muxes and enables. It adds memory wait-state handling, optional U-type and JALR support, illegal-opcode detection and a retired-fetch counter.

## Interface
- EXT_OPS, 1: 1 enables lui/auipc/jalr; 0 treats those opcodes as illegal.
- ILLEGAL_HALT, 1: 1 makes TRAP absorbing until reset; 0 makes TRAP return to FETCH after one cycle.
- RET_W, 32: width of instret counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  IR opcode, valid from DECODE onward.
- mem_ready  in  1  shared memory completes access this cycle.
- PCUpdate  out  1  PC write enable.
- Branch  out  1  PC write if ALU Zero.
- RegWrite  out  1  register file write.
- MemWrite  out  1  data memory write request.
- IRWrite  out  1  IR/OldPC load.
- AdrSrc  out  1  0=PC, 1=Result.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rd1, 11=zero.
- ALUSrcB  out  2  00=rd2, 01=imm, 10=const 4.
- ALUOp  out  2  00=add, 01=sub, 10=funct-decoded.
- ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U.
- illegal  out  1  in TRAP state.
- state_o  out  4  current state code.
- instret  out  RET_W  count of accepted fetches.

## Operation
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, LUI 11, AUIPC 12, JALR 13, TRAP 14. Code 15 unreachable; it goes to FETCH.
- Unlisted outputs are 0. Unlisted mux selects are 00.
- FETCH: AdrSrc=0, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=mem_ready. Go to DECODE when mem_ready, else hold.
- DECODE: SrcA=01, SrcB=01, ALUOp=00. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - with EXT_OPS: 0110111 → LUI, 0010111 → AUIPC, 1100111 → JALR
  - otherwise → TRAP
- MEMADR: SrcA=10, SrcB=01. Go to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held asserted until mem_ready. Then FETCH.
- EXECUTER: SrcA=10, SrcB=00, ALUOp=10. Go to ALUWB.
- EXECUTEI: SrcA=10, SrcB=01, ALUOp=10. Go to ALUWB.
- ALUWB: RegWrite=1. Go to FETCH.
- BEQ: SrcA=10, SrcB=00, ALUOp=01, Branch=1. Go to FETCH.
- JAL: SrcA=01, SrcB=10, PCUpdate=1. Go to ALUWB.
- LUI: SrcA=11, SrcB=01. Go to ALUWB.
- AUIPC: SrcA=01, SrcB=01. Go to ALUWB.
- JALR: SrcA=10, SrcB=01. Go to JAL, which loads PC from ALUOut and writes OldPC+4 to rd.
- TRAP: illegal=1. Go to FETCH if ILLEGAL_HALT=0, else hold.
- ImmSrc is combinational from op in every state: lw/opimm/jalr→000, sw→001, beq→010, jal→011, lui/auipc→100, other→000.
- instret increments by 1 on each FETCH cycle with mem_ready=1. It wraps modulo 2^RET_W.

## Timing
- Reset: state=FETCH, instret=0. Outputs take their FETCH values immediately (IRWrite/PCUpdate follow mem_ready); illegal=0.
- Reset mid-operation forces FETCH asynchronously. MemWrite deasserts at once.
- Outputs are Moore decodes of the state register. The only Mealy terms are IRWrite and PCUpdate in FETCH, gated by mem_ready.
- op is sampled only in DECODE and MEMADR.
- Cycles per instruction with mem_ready=1: beq 3; R/I-ALU, sw, jal, lui, auipc 4; lw, jalr 5. Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

## Test plan
- Reset with mem_ready=1, op=0110011 → state_o sequence 0,1,6,8,0. RegWrite=1 only in state 8. instret=1 after the first FETCH edge.
- lw with mem_ready low for 2 cycles in MEMREAD → sequence 0,1,2,3,3,3,4,0. AdrSrc=1 in state 3. ResultSrc=01 with RegWrite=1 in state 4.
- sw with mem_ready=0 for 3 cycles → MemWrite held 4 cycles in state 5, then FETCH. RegWrite never 1.
- EXT_OPS=1, op=1100111 → sequence 0,1,13,10,8,0. PCUpdate=1 in state 10. ImmSrc=000 throughout.
- EXT_OPS=0, op=0110111 → state 14, illegal=1. With ILLEGAL_HALT=1, state stays 14 for 10 cycles until rst_n low. With ILLEGAL_HALT=0, state returns to 0 next cycle.
- RET_W=4, 16 back-to-back beq → instret wraps 15→0. Asserting rst_n low mid-BEQ gives state_o=0 and instret=0 before the next clock edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multi-cycle RV32I datapath. One ALU and one memory port
// are shared across the fetch, decode, execute, memory and writeback steps.
// This block drives the datapath mux selects and write enables for each step.
//
// Parameters
//   EXT_OPS      1: lui/auipc/jalr are executed. 0: they trap as illegal.
//   ILLEGAL_HALT 1: TRAP holds until reset. 0: TRAP returns to FETCH.
//   RET_W        width of the instret counter (wraps modulo 2^RET_W).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   op         IR opcode, valid from DECODE onward
//   mem_ready  shared memory completes the current access this cycle
//   PCUpdate   PC write enable
//   Branch     PC write if ALU Zero
//   RegWrite   register file write
//   MemWrite   data memory write request
//   IRWrite    IR/OldPC load
//   AdrSrc     memory address: 0=PC, 1=Result
//   ResultSrc  00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA    00=PC, 01=OldPC, 10=rd1, 11=zero
//   ALUSrcB    00=rd2, 01=imm, 10=const 4
//   ALUOp      00=add, 01=sub, 10=funct-decoded
//   ImmSrc     000=I, 001=S, 010=B, 011=J, 100=U
//   illegal    high while in TRAP
//   state_o    current state code
//   instret    count of accepted fetches
//
// Memory handshake: an access is requested for every cycle spent in FETCH,
// MEMREAD or MEMWRITE, and it completes on the rising edge at the end of a
// cycle in which mem_ready is high. The request (address select, MemWrite)
// stays asserted until then. mem_ready is ignored in every other state.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter bit          EXT_OPS      = 1'b1,
   parameter bit          ILLEGAL_HALT = 1'b1,
   parameter int unsigned RET_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       op,
   input  logic             mem_ready,
   output logic             PCUpdate,
   output logic             Branch,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             AdrSrc,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [2:0]       ImmSrc,
   output logic             illegal,
   output logic [3:0]       state_o,
   output logic [RET_W-1:0] instret
);

   // State codes
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECUTER = 4'd6;
   localparam logic [3:0] S_EXECUTEI = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BEQ      = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_LUI      = 4'd11;
   localparam logic [3:0] S_AUIPC    = 4'd12;
   localparam logic [3:0] S_JALR     = 4'd13;
   localparam logic [3:0] S_TRAP     = 4'd14;

   // Opcodes
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   logic [3:0]       state_q, state_d;
   logic [RET_W-1:0] instret_q, instret_d;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD,
               OP_STORE: state_d = S_MEMADR;
               OP_RTYPE: state_d = S_EXECUTER;
               OP_ITYPE: state_d = S_EXECUTEI;
               OP_BEQ:   state_d = S_BEQ;
               OP_JAL:   state_d = S_JAL;
               OP_LUI:   state_d = EXT_OPS ? S_LUI   : S_TRAP;
               OP_AUIPC: state_d = EXT_OPS ? S_AUIPC : S_TRAP;
               OP_JALR:  state_d = EXT_OPS ? S_JALR  : S_TRAP;
               default:  state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_LUI:      state_d = S_ALUWB;
         S_AUIPC:    state_d = S_ALUWB;
         // JALR computes rs1+imm into ALUOut, then reuses JAL to load PC from
         // ALUOut and write OldPC+4 to rd.
         S_JALR:     state_d = S_JAL;
         S_TRAP:     state_d = ILLEGAL_HALT ? S_TRAP : S_FETCH;
         default:    state_d = S_FETCH;   // code 15 is unreachable; recover
      endcase
   end

   // Only accepted fetches retire; a stalled FETCH cycle does not count.
   always_comb begin
      instret_d = instret_q;
      if (state_q == S_FETCH && mem_ready) instret_d = instret_q + RET_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode: Moore on state_q, except IRWrite/PCUpdate in FETCH which
   // follow mem_ready so the IR and PC load only on the completing cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      PCUpdate  = 1'b0;
      Branch    = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      illegal   = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_ready;
            PCUpdate  = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         S_EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_BEQ: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            Branch  = 1'b1;
         end
         S_JAL: begin
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            PCUpdate = 1'b1;
         end
         S_LUI: begin
            ALUSrcA = 2'b11;
            ALUSrcB = 2'b01;
         end
         S_AUIPC: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_JALR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_TRAP:     illegal = 1'b1;
         default: ;
      endcase
   end

   // Immediate format follows the opcode in every state, independent of
   // EXT_OPS, so the immediate generator is ready as soon as the IR loads.
   always_comb begin
      case (op)
         OP_STORE:         ImmSrc = 3'b001;
         OP_BEQ:           ImmSrc = 3'b010;
         OP_JAL:           ImmSrc = 3'b011;
         OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
         default:          ImmSrc = 3'b000;
      endcase
   end

   assign state_o = state_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Three instances share clk, rst_n, op and mem_ready:
//   [0] EXT_OPS=1 ILLEGAL_HALT=1 RET_W=4
//   [1] EXT_OPS=0 ILLEGAL_HALT=0 RET_W=32
//   [2] EXT_OPS=0 ILLEGAL_HALT=1 RET_W=32
// A reference model built from the instruction step tables is compared with
// every output of every instance on each falling edge; directed runs compare
// recorded state traces and a few signal counts with hand-derived literals.
// Inputs change 1 time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       rst_n;
   logic [6:0] op;
   logic       mem_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT outputs ----------------
   logic       pcu[3], brn[3], rgw[3], mmw[3], irw[3], adr[3], ill[3];
   logic [1:0] rsr[3], sra[3], srb[3], aop[3];
   logic [2:0] imm[3];
   logic [3:0] st[3];
   logic [3:0]  ret_a;
   logic [31:0] ret_b, ret_c;

   multicycle_ctrl #(.EXT_OPS(1'b1), .ILLEGAL_HALT(1'b1), .RET_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .PCUpdate(pcu[0]), .Branch(brn[0]), .RegWrite(rgw[0]), .MemWrite(mmw[0]),
      .IRWrite(irw[0]), .AdrSrc(adr[0]), .ResultSrc(rsr[0]), .ALUSrcA(sra[0]),
      .ALUSrcB(srb[0]), .ALUOp(aop[0]), .ImmSrc(imm[0]), .illegal(ill[0]),
      .state_o(st[0]), .instret(ret_a));

   multicycle_ctrl #(.EXT_OPS(1'b0), .ILLEGAL_HALT(1'b0), .RET_W(32)) dut_b (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .PCUpdate(pcu[1]), .Branch(brn[1]), .RegWrite(rgw[1]), .MemWrite(mmw[1]),
      .IRWrite(irw[1]), .AdrSrc(adr[1]), .ResultSrc(rsr[1]), .ALUSrcA(sra[1]),
      .ALUSrcB(srb[1]), .ALUOp(aop[1]), .ImmSrc(imm[1]), .illegal(ill[1]),
      .state_o(st[1]), .instret(ret_b));

   multicycle_ctrl #(.EXT_OPS(1'b0), .ILLEGAL_HALT(1'b1), .RET_W(32)) dut_c (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .PCUpdate(pcu[2]), .Branch(brn[2]), .RegWrite(rgw[2]), .MemWrite(mmw[2]),
      .IRWrite(irw[2]), .AdrSrc(adr[2]), .ResultSrc(rsr[2]), .ALUSrcA(sra[2]),
      .ALUSrcB(srb[2]), .ALUOp(aop[2]), .ImmSrc(imm[2]), .illegal(ill[2]),
      .state_o(st[2]), .instret(ret_c));

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit p_ext(input int k);
      return (k == 0);
   endfunction

   function automatic bit p_halt(input int k);
      return (k != 1);
   endfunction

   function automatic logic [31:0] ret_mask(input int k);
      return (k == 0) ? 32'h0000_000F : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [3:0] m_next(input int k, input logic [3:0] s,
                                         input logic [6:0] o, input logic mr);
      logic [3:0] n;
      n = 4'd0;
      case (s)
         4'd0:  n = mr ? 4'd1 : 4'd0;
         4'd1: begin
            if (o == 7'b0000011 || o == 7'b0100011) n = 4'd2;
            else if (o == 7'b0110011) n = 4'd6;
            else if (o == 7'b0010011) n = 4'd7;
            else if (o == 7'b1100011) n = 4'd9;
            else if (o == 7'b1101111) n = 4'd10;
            else if (p_ext(k) && o == 7'b0110111) n = 4'd11;
            else if (p_ext(k) && o == 7'b0010111) n = 4'd12;
            else if (p_ext(k) && o == 7'b1100111) n = 4'd13;
            else n = 4'd14;
         end
         4'd2:  n = (o == 7'b0000011) ? 4'd3 : 4'd5;
         4'd3:  n = mr ? 4'd4 : 4'd3;
         4'd5:  n = mr ? 4'd0 : 4'd5;
         4'd6, 4'd7, 4'd10, 4'd11, 4'd12: n = 4'd8;
         4'd13: n = 4'd10;
         4'd14: n = p_halt(k) ? 4'd14 : 4'd0;
         default: n = 4'd0;
      endcase
      return n;
   endfunction

   // {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,
   //  ALUSrcB,ALUOp,ImmSrc,illegal,state}
   function automatic logic [21:0] m_ctrl(input logic [3:0] s, input logic [6:0] o,
                                          input logic mr);
      logic       pc, br, rw, mw, ir, ad, il;
      logic [1:0] rs, sa, sb, ao;
      logic [2:0] im;
      {pc, br, rw, mw, ir, ad, il} = 7'b0;
      {rs, sa, sb, ao} = 8'b0;
      case (s)
         4'd0:  begin sb = 2'b10; rs = 2'b10; ir = mr; pc = mr; end
         4'd1:  begin sa = 2'b01; sb = 2'b01; end
         4'd2:  begin sa = 2'b10; sb = 2'b01; end
         4'd3:  ad = 1'b1;
         4'd4:  begin rs = 2'b01; rw = 1'b1; end
         4'd5:  begin ad = 1'b1; mw = 1'b1; end
         4'd6:  begin sa = 2'b10; ao = 2'b10; end
         4'd7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
         4'd8:  rw = 1'b1;
         4'd9:  begin sa = 2'b10; ao = 2'b01; br = 1'b1; end
         4'd10: begin sa = 2'b01; sb = 2'b10; pc = 1'b1; end
         4'd11: begin sa = 2'b11; sb = 2'b01; end
         4'd12: begin sa = 2'b01; sb = 2'b01; end
         4'd13: begin sa = 2'b10; sb = 2'b01; end
         4'd14: il = 1'b1;
         default: ;
      endcase
      if (o == 7'b0100011) im = 3'b001;
      else if (o == 7'b1100011) im = 3'b010;
      else if (o == 7'b1101111) im = 3'b011;
      else if (o == 7'b0110111 || o == 7'b0010111) im = 3'b100;
      else im = 3'b000;
      return {pc, br, rw, mw, ir, ad, rs, sa, sb, ao, im, il, s};
   endfunction

   function automatic logic [21:0] dut_word(input int k);
      return {pcu[k], brn[k], rgw[k], mmw[k], irw[k], adr[k], rsr[k], sra[k],
              srb[k], aop[k], imm[k], ill[k], st[k]};
   endfunction

   function automatic logic [31:0] dut_ret(input int k);
      if (k == 0) return {28'd0, ret_a};
      else if (k == 1) return ret_b;
      else return ret_c;
   endfunction

   logic [3:0]  m_state[3];
   logic [31:0] m_ret[3];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 3; k++) begin
            m_state[k] <= 4'd0;
            m_ret[k]   <= 32'd0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (m_state[k] == 4'd0 && mem_ready) m_ret[k] <= (m_ret[k] + 32'd1) & ret_mask(k);
            m_state[k] <= m_next(k, m_state[k], op, mem_ready);
         end
      end
   end

   // Per-cycle compare of every output against the model
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         check($sformatf("ctrl%0d", k), 64'(dut_word(k)), 64'(m_ctrl(m_state[k], op, mem_ready)));
         check($sformatf("instret%0d", k), 64'(dut_ret(k)), 64'(m_ret[k]));
      end
   end

   // ---------------- driver tasks ----------------
   int cnt_rw, cnt_mw, cnt_pcu, cnt_imm;

   // Called just after a falling edge. Asserts reset asynchronously, checks
   // the reset values before any clock edge, then releases after one edge.
   task automatic do_reset();
      mem_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst_state", 64'({st[0], st[1], st[2]}), 64'h0);
      check("rst_ret_a", 64'(ret_a), 64'h0);
      check("rst_ret_b", 64'(ret_b), 64'h0);
      check("rst_illegal_memwrite", 64'({ill[0], ill[1], ill[2], mmw[0]}), 64'h0);
      check("rst_fetch_outs",
            64'({irw[0], pcu[0], adr[0], sra[0], srb[0], aop[0], rsr[0]}),
            64'(11'b1_1_0_00_10_00_10));
      @(negedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Starts in FETCH just after a falling edge. Records n states per instance
   // (first is the current FETCH, last is the next FETCH) and stalls memory
   // for 'stalls' cycles while instance 0 sits in stall_st.
   task automatic run_seq(input string name, input logic [6:0] op_v,
                          input logic [3:0] stall_st, input int stalls, input int n,
                          input logic [63:0] ea, input logic [63:0] eb,
                          input logic [63:0] ec);
      logic [63:0] ta, tb, tc;
      int left;
      ta = '0; tb = '0; tc = '0;
      left = stalls;
      cnt_rw = 0; cnt_mw = 0; cnt_pcu = 0; cnt_imm = 0;
      op = op_v;
      #1;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin @(negedge clk); #1; end
         ta = {ta[59:0], st[0]};
         tb = {tb[59:0], st[1]};
         tc = {tc[59:0], st[2]};
         if (rgw[0]) cnt_rw++;
         if (mmw[0]) cnt_mw++;
         if (st[0] != 4'd0 && pcu[0]) cnt_pcu++;
         if (imm[0] != 3'b000) cnt_imm++;
         if (st[0] == stall_st && left > 0) begin
            mem_ready = 1'b0;
            left--;
         end else begin
            mem_ready = 1'b1;
         end
      end
      check({name, "_seq_a"}, ta, ea);
      check({name, "_seq_b"}, tb, eb);
      check({name, "_seq_c"}, tc, ec);
   endtask

   // Advance instance 0 until it reaches target (bounded)
   task automatic go_to(input logic [6:0] op_v, input logic [3:0] target);
      int c;
      c = 0;
      op = op_v;
      while (st[0] != target && c < 12) begin
         mem_ready = 1'b1;
         @(negedge clk); #1;
         c++;
      end
      check("goto_state", 64'(st[0]), 64'(target));
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst_n = 1'b0;
      mem_ready = 1'b1;
      op = 7'b0110011;
      @(negedge clk); #1;
      do_reset();

      // R-type: 0,1,6,8,0 ; RegWrite only in ALUWB ; one fetch retired
      run_seq("rtype", 7'b0110011, 4'hF, 0, 5, 64'h01680, 64'h01680, 64'h01680);
      check("rtype_regwrite_cycles", 64'(cnt_rw), 64'd1);
      check("instret_after_first", 64'(ret_a), 64'd1);

      // lw with two wait cycles in MEMREAD
      run_seq("lw", 7'b0000011, 4'd3, 2, 8, 64'h01233340, 64'h01233340, 64'h01233340);
      check("lw_regwrite_cycles", 64'(cnt_rw), 64'd1);

      // sw with three wait cycles in MEMWRITE
      run_seq("sw", 7'b0100011, 4'd5, 3, 8, 64'h01255550, 64'h01255550, 64'h01255550);
      check("sw_memwrite_cycles", 64'(cnt_mw), 64'd4);
      check("sw_regwrite_cycles", 64'(cnt_rw), 64'd0);
      check("instret_after_sw", 64'(ret_b), 64'd3);

      // jalr: legal on [0], illegal on [1] (recovers) and [2] (halts)
      @(negedge clk); #1;
      do_reset();
      run_seq("jalr", 7'b1100111, 4'hF, 0, 6, 64'h01DA80, 64'h01E01E, 64'h01EEEE);
      check("jalr_pcupdate_cycles", 64'(cnt_pcu), 64'd1);
      check("jalr_immsrc_nonzero", 64'(cnt_imm), 64'd0);

      // lui: legal on [0]; trap on [1],[2]; [2] stays trapped until reset
      do_reset();
      run_seq("lui", 7'b0110111, 4'hF, 0, 5, 64'h01B80, 64'h01E01, 64'h01EEE);
      begin
         int held;
         held = 0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            mem_ready = 1'b1;
            if (st[2] == 4'd14 && ill[2]) held++;
         end
         check("halt_held_cycles", 64'(held), 64'd10);
      end
      do_reset();

      // 16 back-to-back beq: 4-bit counter wraps 15 -> 0
      for (int j = 0; j < 16; j++) begin
         run_seq("beq", 7'b1100011, 4'hF, 0, 4, 64'h0190, 64'h0190, 64'h0190);
         if (j == 14) begin
            check("instret_a_15", 64'(ret_a), 64'd15);
            check("instret_b_15", 64'(ret_b), 64'd15);
         end
      end
      check("instret_a_wrap", 64'(ret_a), 64'd0);
      check("instret_b_16", 64'(ret_b), 64'd16);

      // Reset in the middle of BEQ
      go_to(7'b1100011, 4'd9);
      check("pre_rst_instret_a", 64'(ret_a), 64'd1);
      do_reset();

      // Reset in the middle of MEMWRITE: MemWrite drops without a clock edge
      go_to(7'b0100011, 4'd5);
      check("pre_rst_memwrite", 64'(mmw[0]), 64'd1);
      do_reset();

      run_seq("itype", 7'b0010011, 4'hF, 0, 5, 64'h01780, 64'h01780, 64'h01780);

      @(negedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
